// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and constants for the dmem_responder slice.
// Optional access counters are enabled with DMEM_ACCESS_CNT_EN.
package dmem_pkg;

    localparam int DMEM_ADDR_W   = 7;
    localparam int DMEM_DATA_W   = 32;
    localparam int DMEM_WAIT_MAX = 7;
    localparam int DMEM_CNT_W    = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } dmem_state_e;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [DMEM_CNT_W-1:0] sat_inc(
        input logic [DMEM_CNT_W-1:0] v
    );
        if (v == {DMEM_CNT_W{1'b1}}) begin
            return v;
        end
        return v + 1'b1;
    endfunction

endpackage

// File: rtl/dmem_array.sv
// dmem_array: DEPTH x 32 storage, synchronous write, combinational read.
// Contents are never reset. Used by dmem_responder (DMEM_ACCESS_CNT_EN agnostic).
module dmem_array
    import dmem_pkg::*;
#(
    parameter int DEPTH = 128
) (
    input  logic                   clk,
    input  logic                   we,
    input  logic [DMEM_ADDR_W-1:0] addr,
    input  logic [DMEM_DATA_W-1:0] wdata,
    output logic [DMEM_DATA_W-1:0] rdata
);

    logic [DMEM_DATA_W-1:0] mem [DEPTH];

    // Write port: one word per enabled edge.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: SRAM-style data memory slave with fixed wait states.
// Define DMEM_ACCESS_CNT_EN to add the rd_cnt/wr_cnt completion counters.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int WAIT_STATES = 1,
    parameter int DEPTH       = 128
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   CEN,
    input  logic                   WEN,
    input  logic                   OEN,
    input  logic [DMEM_ADDR_W-1:0] A,
    input  logic [DMEM_DATA_W-1:0] D,
    output logic [DMEM_DATA_W-1:0] Q,
    output logic                   ready
`ifdef DMEM_ACCESS_CNT_EN
   ,output logic [DMEM_CNT_W-1:0]  rd_cnt,
    output logic [DMEM_CNT_W-1:0]  wr_cnt
`endif
);

    // Out-of-range settings clamp to the largest supported wait count.
    localparam logic [2:0] WAIT_LOAD =
        (WAIT_STATES > DMEM_WAIT_MAX) ? 3'(DMEM_WAIT_MAX)
                                      : 3'(WAIT_STATES);

    dmem_state_e state;
    dmem_state_e state_next;

    logic [2:0]             wait_cnt;
    logic [DMEM_ADDR_W-1:0] a_lat;
    logic [DMEM_DATA_W-1:0] d_lat;
    logic                   wen_lat;
    logic [DMEM_DATA_W-1:0] q_reg;

    logic                   accept;
    logic                   complete;
    logic                   mem_we;
    logic [DMEM_DATA_W-1:0] mem_rdata;

    // Next-state and event decode; request inputs matter only in IDLE.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        complete   = 1'b0;
        unique case (state)
            IDLE: begin
                if (!CEN) begin
                    accept     = 1'b1;
                    state_next = BUSY;
                end
            end
            BUSY: begin
                if (wait_cnt == 3'd0) begin
                    complete   = 1'b1;
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Request capture at accept; held stable for the whole access.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_lat   <= '0;
            d_lat   <= '0;
            wen_lat <= 1'b1;
        end else if (accept) begin
            a_lat   <= A;
            d_lat   <= D;
            wen_lat <= WEN;
        end
    end

    // Wait countdown, read data register and completion pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt <= 3'd0;
            q_reg    <= '0;
            ready    <= 1'b0;
        end else begin
            ready <= complete;
            if (accept) begin
                wait_cnt <= WAIT_LOAD;
            end else if (state == BUSY && wait_cnt != 3'd0) begin
                wait_cnt <= wait_cnt - 3'd1;
            end
            if (complete && wen_lat) begin
                q_reg <= mem_rdata;
            end
        end
    end

    // A reset landing on the completion edge must still drop the write.
    assign mem_we = complete && !wen_lat && !rst;

    dmem_array #(
        .DEPTH (DEPTH)
    ) u_array (
        .clk   (clk),
        .we    (mem_we),
        .addr  (a_lat),
        .wdata (d_lat),
        .rdata (mem_rdata)
    );

    assign Q = OEN ? '0 : q_reg;

`ifdef DMEM_ACCESS_CNT_EN
    // Saturating completion counters, one per access direction.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_cnt <= '0;
            wr_cnt <= '0;
        end else if (complete) begin
            if (wen_lat) begin
                rd_cnt <= sat_inc(rd_cnt);
            end else begin
                wr_cnt <= sat_inc(wr_cnt);
            end
        end
    end
`endif

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, with ports clk and rst.
REQ-002 Parameter WAIT_STATES SHALL default to 1, range 0..7, giving extra cycles inserted before each access completes.
REQ-003 Parameter DEPTH SHALL default to 128, giving the number of 32-bit words; the address width is 7 bits.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 CEN  input  1  chip enable, active low; 0 requests an access.
REQ-007 WEN  input  1  0 selects write, 1 selects read; sampled with CEN.
REQ-008 OEN  input  1  output enable, active low; 1 forces Q to 0.
REQ-009 A  input  7  word address.
REQ-010 D  input  32  write data, the initiator's store operand.
REQ-011 Q  output  32  read data returned to the initiator.
REQ-012 ready  output  1  one-cycle pulse marking access completion.
REQ-013 rd_cnt and wr_cnt SHALL be outputs, 16 bits each, counting completed accesses; they exist only with DMEM_ACCESS_CNT_EN.

Function
REQ-014 The FSM SHALL have the states IDLE, BUSY and DONE, encoded in 2 bits.
REQ-015 In IDLE, a rising edge with CEN=0 SHALL accept the request: latch A, D and WEN, load wait_cnt with WAIT_STATES, and go to BUSY.
REQ-016 In BUSY with wait_cnt not 0, each edge SHALL decrement wait_cnt by 1; CEN, WEN, A and D are ignored.
REQ-017 In BUSY with wait_cnt=0, the edge SHALL perform the latched access and go to DONE.
- Write: array[A_latched] <= D_latched.
- Read: Q_reg <= array[A_latched].
REQ-018 In DONE, ready SHALL be 1, and the next edge SHALL return the FSM to IDLE unconditionally.
REQ-019 Completion latency SHALL be fixed: ready is high in the cycle after edge WAIT_STATES+1 counted from the accept edge.
- WAIT_STATES=0 gives ready 2 cycles after CEN is first sampled low.
REQ-020 ready SHALL be 0 in IDLE and BUSY, so it is never high for two consecutive cycles.
REQ-021 Back-to-back requests SHALL take at least WAIT_STATES+3 cycles each; a CEN=0 presented during DONE is ignored.
REQ-022 Q SHALL equal Q_reg when OEN=0 and 32'h0 when OEN=1; Q_reg holds its value until the next read completes.
REQ-023 A write SHALL leave Q_reg unchanged.
REQ-024 Read-after-write to the same address SHALL return the newly written data.
REQ-025 An address at or beyond DEPTH cannot occur because A is 7 bits and DEPTH is 128; no bounds checking is required.

Reset
REQ-026 rst=1 SHALL force the following at the next edge, taking priority over every other event:
- state <= IDLE;
- wait_cnt <= 0;
- Q_reg <= 0;
- ready <= 0;
- rd_cnt and wr_cnt <= 0, when present.
REQ-027 A reset during BUSY SHALL abort the access: a pending write is discarded and the array is unchanged.
REQ-028 Array contents SHALL NOT be cleared by reset.

Configuration
REQ-029 When DMEM_ACCESS_CNT_EN is defined, the block SHALL provide rd_cnt and wr_cnt.
- Each counter increments by 1 on the edge that completes a read or a write, respectively.
- Each counter saturates at 16'hFFFF.
REQ-030 When DMEM_ACCESS_CNT_EN is undefined, the block SHALL omit the counter ports and logic; all other behaviour is identical.

Structure
REQ-031 Package dmem_pkg SHALL hold the following:
- the state typedef (IDLE=0, BUSY=1, DONE=2);
- DMEM_ADDR_W=7;
- DMEM_DATA_W=32;
- the WAIT_STATES maximum of 7.
REQ-032 Storage SHALL be a single sub-module, dmem_array.
- DEPTH x 32 bits.
- Synchronous write on we.
- Combinational read.
- No reset.
REQ-033 The FSM, latches and counters SHALL reside in dmem_responder.

Verification
REQ-034 Write then read, WAIT_STATES=1: write D=32'hDEADBEEF at A=5, then read A=5 with OEN=0. Required: ready on cycle 3 after each request, and Q=32'hDEADBEEF.
REQ-035 OEN gating: after REQ-034, set OEN=1. Required: Q=0. Then set OEN=0. Required: Q=32'hDEADBEEF with no new access.
REQ-036 Latency sweep: read A=0 with WAIT_STATES equal to 0, 3 and 7. Required: ready exactly 2, 5 and 9 cycles after the accept edge, each a single-cycle pulse.
REQ-037 Input change during BUSY: change A from 10 to 20 and D while BUSY on a write. Required: only array[10] is written.
REQ-038 Reset mid-write: assert rst in the BUSY cycle of a write of 32'h1234 to A=7, where array[7]=32'hAAAA. Required: ready stays 0, Q=0, and a later read of A=7 returns 32'hAAAA.
REQ-039 Counters, with DMEM_ACCESS_CNT_EN: perform 3 writes and 2 reads. Required: wr_cnt=3 and rd_cnt=2; after preloading to 16'hFFFF, a further read leaves rd_cnt at 16'hFFFF.
